// File: rtl/uart_rx.sv
// 8N1 UART receiver: oversamples a synchronised serial line on a shared baud tick
// and emits each good byte with a one-clock valid pulse, or a one-clock framing error.
module uart_rx #(
  parameter int unsigned N       = 8,
  parameter int unsigned OVS     = 16,
  parameter int unsigned SB_TICK = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_rx,
  input  logic         i_tick,
  output logic [N-1:0] o_data,
  output logic         o_rx_valid,
  output logic         o_frame_err
);

  localparam int unsigned TMAX = (OVS > SB_TICK) ? OVS : SB_TICK;
  localparam int unsigned TW   = (TMAX > 1) ? $clog2(TMAX) : 1;
  localparam int unsigned BW   = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_STOP  = 3'd3,
    S_BREAK = 3'd4
  } state_t;

  state_t        state_q, state_d;
  logic [TW-1:0] tick_q, tick_d;
  logic [BW-1:0] bit_q, bit_d;
  logic [N-1:0]  shift_q, shift_d;
  logic [N-1:0]  data_q, data_d;
  logic          valid_q, valid_d;
  logic          ferr_q, ferr_d;
  logic          rx_meta, rx_s;

  // Two-flop synchroniser; resets to the idle line level
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= i_rx;
      rx_s    <= rx_meta;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      tick_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      tick_q  <= tick_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
    end
  end

  // Next-state: counters only advance on a baud tick; pulses default low
  always_comb begin
    state_d = state_q;
    tick_d  = tick_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    data_d  = data_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!rx_s) begin
          state_d = S_START;
          tick_d  = '0;
        end
      end
      S_START: begin
        if (i_tick) begin
          if (tick_q == TW'(OVS / 2 - 1)) begin
            if (!rx_s) begin
              state_d = S_DATA;
              tick_d  = '0;
              bit_d   = '0;
            end else begin
              state_d = S_IDLE;
            end
          end else begin
            tick_d = tick_q + TW'(1);
          end
        end
      end
      S_DATA: begin
        if (i_tick) begin
          if (tick_q == TW'(OVS - 1)) begin
            shift_d = {rx_s, shift_q[N-1:1]};
            tick_d  = '0;
            if (bit_q == BW'(N - 1)) begin
              state_d = S_STOP;
            end else begin
              bit_d = bit_q + BW'(1);
            end
          end else begin
            tick_d = tick_q + TW'(1);
          end
        end
      end
      S_STOP: begin
        if (i_tick) begin
          if (tick_q == TW'(SB_TICK - 1)) begin
            if (rx_s) begin
              data_d  = shift_q;
              valid_d = 1'b1;
              state_d = S_IDLE;
            end else begin
              ferr_d  = 1'b1;
              state_d = S_BREAK;
            end
          end else begin
            tick_d = tick_q + TW'(1);
          end
        end
      end
      S_BREAK: begin
        if (rx_s) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign o_data      = data_q;
  assign o_rx_valid  = valid_q;
  assign o_frame_err = ferr_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: a tick-paced serial driver and a pulse monitor,
// with expected bytes and event counts written out by hand per step.
module tb_uart_rx;

  localparam int unsigned TICK_DIV = 16;
  localparam int unsigned BIT_T    = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic       i_rx;
  logic       i_tick;
  logic [7:0] o_data;
  logic       o_rx_valid;
  logic       o_frame_err;

  int         errors = 0;
  int         checks = 0;
  logic       tick_en = 1'b1;
  int         tcnt = 0;
  int         tick_total = 0;
  int         nvalid = 0;
  int         nferr = 0;
  int         nboth = 0;
  logic [7:0] rxq[$];

  uart_rx #(.N(8), .OVS(16), .SB_TICK(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .i_rx       (i_rx),
    .i_tick     (i_tick),
    .o_data     (o_data),
    .o_rx_valid (o_rx_valid),
    .o_frame_err(o_frame_err)
  );

  always #5 clk = ~clk;

  assign i_tick = tick_en && (tcnt == TICK_DIV - 1);

  always @(posedge clk) begin
    if (tick_en) tcnt <= (tcnt == TICK_DIV - 1) ? 0 : tcnt + 1;
    if (i_tick) tick_total <= tick_total + 1;
  end

  // Pulse monitor, sampled on the falling edge
  always @(negedge clk) begin
    if (rst) begin
      if (o_rx_valid) begin
        nvalid <= nvalid + 1;
        rxq.push_back(o_data);
      end
      if (o_frame_err) nferr <= nferr + 1;
      if (o_rx_valid && o_frame_err) nboth <= nboth + 1;
    end
  end

  initial begin
    #20ms;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_ticks(input int n);
    int target;
    target = tick_total + n;
    while (tick_total < target) @(negedge clk);
  endtask

  // Drives one frame; freeze_bit >= 0 stops the tick mid-way through that data bit
  task automatic send_frame(input logic [7:0] b, input logic stop, input int freeze_bit);
    @(negedge clk);
    i_rx = 1'b0;
    wait_ticks(BIT_T);
    for (int i = 0; i < 8; i++) begin
      i_rx = b[i];
      if (i == freeze_bit) begin
        wait_ticks(BIT_T / 2);
        tick_en = 1'b0;
        repeat (500) @(negedge clk);
        chk("freeze_no_valid", 32'(nvalid), 32'd6);
        chk("freeze_no_ferr", 32'(nferr), 32'd1);
        tick_en = 1'b1;
        wait_ticks(BIT_T / 2);
      end else begin
        wait_ticks(BIT_T);
      end
    end
    i_rx = stop;
    wait_ticks(BIT_T);
  endtask

  initial begin
    rst  = 1'b0;
    i_rx = 1'b1;
    repeat (5) @(negedge clk);
    chk("reset_data", 32'(o_data), 32'h0);
    chk("reset_valid", 32'(o_rx_valid), 32'd0);
    chk("reset_ferr", 32'(o_frame_err), 32'd0);
    rst = 1'b1;
    wait_ticks(20);

    // 1: single frame
    send_frame(8'h01, 1'b1, -1);
    chk("t1_count", 32'(nvalid), 32'd1);
    chk("t1_data", 32'(o_data), 32'h01);
    chk("t1_byte", 32'(rxq[0]), 32'h01);
    chk("t1_ferr", 32'(nferr), 32'd0);

    // 2: back-to-back frames with no idle gap
    send_frame(8'h10, 1'b1, -1);
    send_frame(8'h02, 1'b1, -1);
    chk("t2_count", 32'(nvalid), 32'd3);
    chk("t2_first", 32'(rxq[1]), 32'h10);
    chk("t2_second", 32'(rxq[2]), 32'h02);
    chk("t2_data", 32'(o_data), 32'h02);

    // 3: short low glitch rejected, then a real frame
    @(negedge clk);
    i_rx = 1'b0;
    wait_ticks(3);
    i_rx = 1'b1;
    wait_ticks(BIT_T * 2);
    chk("t3_glitch_count", 32'(nvalid), 32'd3);
    chk("t3_glitch_ferr", 32'(nferr), 32'd0);
    send_frame(8'hAA, 1'b1, -1);
    chk("t3_count", 32'(nvalid), 32'd4);
    chk("t3_data", 32'(o_data), 32'hAA);

    // 4: bad stop bit followed by a long break, then recovery
    send_frame(8'h55, 1'b0, -1);
    wait_ticks(BIT_T * 10 * 2);
    i_rx = 1'b1;
    wait_ticks(BIT_T * 2);
    chk("t4_ferr", 32'(nferr), 32'd1);
    chk("t4_no_valid", 32'(nvalid), 32'd4);
    chk("t4_data_held", 32'(o_data), 32'hAA);
    send_frame(8'h04, 1'b1, -1);
    chk("t4_count", 32'(nvalid), 32'd5);
    chk("t4_data", 32'(o_data), 32'h04);
    chk("t4_ferr_after", 32'(nferr), 32'd1);

    // 5: reset during data bit 3 of 0x33
    @(negedge clk);
    i_rx = 1'b0;
    wait_ticks(BIT_T);
    for (int i = 0; i < 3; i++) begin
      i_rx = 1'(8'h33 >> i);
      wait_ticks(BIT_T);
    end
    i_rx = 1'b0;
    wait_ticks(BIT_T / 2);
    rst = 1'b0;
    #1;
    chk("t5_rst_data", 32'(o_data), 32'h0);
    chk("t5_rst_valid", 32'(o_rx_valid), 32'd0);
    chk("t5_rst_ferr", 32'(o_frame_err), 32'd0);
    i_rx = 1'b1;
    repeat (10) @(negedge clk);
    rst = 1'b1;
    wait_ticks(BIT_T * 12);
    chk("t5_no_partial", 32'(nvalid), 32'd5);
    send_frame(8'h20, 1'b1, -1);
    chk("t5_count", 32'(nvalid), 32'd6);
    chk("t5_data", 32'(o_data), 32'h20);

    // 6: tick frozen mid data bit 4 of 0xC3
    send_frame(8'hC3, 1'b1, 4);
    chk("t6_count", 32'(nvalid), 32'd7);
    chk("t6_data", 32'(o_data), 32'hC3);
    chk("t6_ferr", 32'(nferr), 32'd1);
    chk("never_both", 32'(nboth), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
